multicycle_core: RTL

Parametrised successor to the single-cycle processor top. It is a multi-cycle RV32I-subset core with an internal FSM-sequenced datapath, covering the controller, the ALU control decode and the datapath. It uses one shared, handshaked instruction/data memory port in place of separate combinational memories. It sits between the system memory model/arbiter and the test harness; `result` keeps the role of the old top-level ALU result output.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/mc_alu.sv | 33 +++
 rtl/multicycle_core.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, funct fields,
// ALU operation codes and FSM states.
package riscv_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_e;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multi-cycle core; shifts use the low 5 bits of b.
module mc_alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (alu_op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: y = XLEN'(a < b);
      ALU_SRA:  y = XLEN'($signed(a) >>> shamt);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core with one shared handshaked memory port.
// Optional beq/bne support is enabled by defining BRANCH_EN.
module multicycle_core
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] pc,
  output logic            halted
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  state_e          state, next_state;
  logic [ILEN-1:0] ir;
  logic [XLEN-1:0] op_a, op_b, imm, mdr, alu_b, alu_y, addr_c, imm_c;
  logic [XLEN-1:0] rf [NREGS];
  logic            req_c, we_c;
  logic            legal, use_imm, is_load, is_store, is_branch, uses_rs2, writes_rd;
  alu_op_e         alu_op;
`ifdef BRANCH_EN
  logic [XLEN-1:0] old_pc;
  logic            taken;
`endif

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    return (idx == 5'd0) ? '0 : rf[idx[RIDX_W-1:0]];
  endfunction

  // Instruction decode; IR is stable from DECODE until the next fetch.
  always_comb begin
    legal     = 1'b0;
    use_imm   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    alu_op    = ALU_ADD;
    imm_c     = {{(XLEN-12){ir[31]}}, ir[31:20]};
    case (opcode)
      OPC_OP: begin
        legal     = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}:  alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}:  alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}:  alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}:  alu_op = ALU_SLT;
          {F7_BASE, F3_SLTU}: alu_op = ALU_SLTU;
          {F7_BASE, F3_XOR}:  alu_op = ALU_XOR;
          {F7_BASE, F3_SR}:   alu_op = ALU_SRL;
          {F7_ALT,  F3_SR}:   alu_op = ALU_SRA;
          {F7_BASE, F3_OR}:   alu_op = ALU_OR;
          {F7_BASE, F3_AND}:  alu_op = ALU_AND;
          default:            legal  = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal     = 1'b1;
        use_imm   = 1'b1;
        writes_rd = 1'b1;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          F3_SLL: begin
            alu_op = ALU_SLL;
            legal  = (funct7 == F7_BASE);
          end
          default: begin
            alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_LOAD: begin
        legal     = (funct3 == F3_LW);
        use_imm   = 1'b1;
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        legal    = (funct3 == F3_SW);
        use_imm  = 1'b1;
        is_store = 1'b1;
        uses_rs2 = 1'b1;
        imm_c    = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      end
`ifdef BRANCH_EN
      OPC_BRANCH: begin
        legal     = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        is_branch = 1'b1;
        uses_rs2  = 1'b1;
        alu_op    = ALU_SUB;
        imm_c     = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      end
`else
      OPC_BRANCH: legal = 1'b0;
`endif
      default: legal = 1'b0;
    endcase
    if ((32'(rs1) >= NREGS) || (uses_rs2 && (32'(rs2) >= NREGS)) ||
        (writes_rd && (32'(rd) >= NREGS)))
      legal = 1'b0;
  end

  assign alu_b = use_imm ? imm : op_b;

  mc_alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .y      (alu_y)
  );

`ifdef BRANCH_EN
  assign taken = (funct3 == F3_BNE) ? (op_a != op_b) : (op_a == op_b);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Next state and memory-port controls.
  always_comb begin
    next_state = state;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = pc;
    case (state)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ack) next_state = DECODE;
      end
      DECODE:  next_state = legal ? EXECUTE : HALT;
      EXECUTE: begin
        if (is_load || is_store) next_state = MEM;
        else if (is_branch)      next_state = FETCH;
        else                     next_state = WB;
      end
      MEM: begin
        req_c  = 1'b1;
        we_c   = is_store;
        addr_c = result;
        if (mem_ack) next_state = is_load ? WB : FETCH;
      end
      WB:      next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = HALT;
    endcase
  end

  // Gating with the reset pin drops a pending request the moment reset asserts.
  assign mem_req   = req_c & reset;
  assign mem_we    = we_c;
  assign mem_addr  = {addr_c[XLEN-1:2], 2'b00};
  assign mem_wdata = op_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      imm    <= '0;
      mdr    <= '0;
      result <= '0;
      halted <= 1'b0;
`ifdef BRANCH_EN
      old_pc <= RESET_PC;
`endif
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ack) begin
          ir <= mem_rdata[ILEN-1:0];
          pc <= pc + XLEN'(4);
`ifdef BRANCH_EN
          old_pc <= pc;
`endif
        end
        DECODE: begin
          op_a <= rf_read(rs1);
          op_b <= rf_read(rs2);
          imm  <= imm_c;
          if (!legal) halted <= 1'b1;
        end
        EXECUTE: begin
          result <= alu_y;
`ifdef BRANCH_EN
          if (is_branch && taken) pc <= old_pc + imm;
`endif
        end
        MEM: if (mem_ack && is_load) mdr <= mem_rdata;
        WB: if (rd != 5'd0) rf[rd[RIDX_W-1:0]] <= is_load ? mdr : result;
        default: halted <= 1'b1;
      endcase
    end
  end

endmodule
